// File: rtl/ram_bank_pkg.sv
// ram_bank_pkg: shared types and helpers for the ram_bank memory block.
//   state_e      - fill sequencer state (StFill, StIdle)
//   FILL_ZEROS / FILL_ONES - values of fill_ones selecting the sweep pattern
//   parity_even  - even-parity bit of a word (zero-extended to MaxParityW)
package ram_bank_pkg;

  typedef enum logic {
    StFill = 1'b0,
    StIdle = 1'b1
  } state_e;

  localparam logic FILL_ZEROS = 1'b0;
  localparam logic FILL_ONES  = 1'b1;

  // Widest word the parity helper covers; callers zero-extend, which leaves parity unchanged.
  localparam int unsigned MaxParityW = 64;

  // Bit that makes the XOR of {parity, data} equal to zero.
  function automatic logic parity_even(input logic [MaxParityW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_bank_array.sv
// ram_bank_array: DEPTH x DataW storage with one write port and a registered read port.
// Ports:
//   clk      - clock, all state on rising edge
//   clear_n  - asynchronous active-low reset (read register only; storage is swept)
//   we_i     - write enable, mem[waddr_i] <= wdata_i
//   waddr_i  - write address
//   wdata_i  - write data
//   re_i     - read enable, rdata_o <= mem[raddr_i] at the edge
//   raddr_i  - read address
//   rdata_o  - registered read data, holds when re_i is low
module ram_bank_array #(
  parameter int unsigned DataW = 4,
  parameter int unsigned AddrW = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  // No reset on storage: contents are initialised by the fill sweep.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_bank.sv
// ram_bank: parametrised single-port synchronous RAM bank with req/ready handshake,
// registered read port (latency 1, rvalid pulse) and a hardware fill sequencer that
// sweeps a constant pattern over the whole array after reset or on fill_start.
// Optional feature macro: RAM_BANK_PARITY_EN (per-word even parity, parity_inj, rerr).
// Ports:
//   clk        - clock
//   clear_n    - asynchronous active-low reset; restarts a zero-fill sweep
//   req        - access request, accepted when req & ready
//   we         - 1 = write, 0 = read
//   addr       - word address
//   wdata      - write data
//   fill_start - start a fill sweep (wins over req in the same cycle)
//   fill_ones  - fill pattern select, sampled with fill_start
//   parity_inj - (parity build) store inverted parity with a write
//   rerr       - (parity build) parity mismatch flag, valid with rvalid
//   ready      - access can be accepted this cycle
//   rdata      - registered read data, holds when rvalid is low
//   rvalid     - one-cycle pulse, cycle after a read is accepted
//   busy       - fill sweep in progress
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              fill_start,
  input  logic              fill_ones,
`ifdef RAM_BANK_PARITY_EN
  input  logic              parity_inj,
  output logic              rerr,
`endif
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef RAM_BANK_PARITY_EN
  localparam int unsigned StoreW = DATA_W + 1;
`else
  localparam int unsigned StoreW = DATA_W;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic                rvalid_q, rvalid_d;

  logic                accept;
  logic                arr_we;
  logic                arr_re;
  logic [ADDR_W-1:0]   arr_waddr;
  logic [StoreW-1:0]   arr_wdata;
  logic [StoreW-1:0]   arr_rdata;
  logic [DATA_W-1:0]   wr_data;

  assign busy   = (state_q == StFill);
  assign ready  = (state_q == StIdle) & ~fill_start;
  assign accept = req & ready;
  assign arr_re = accept & ~we;

  // Sequencer next state; fill_start restarts the sweep from either state.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    pattern_d   = pattern_q;
    rvalid_d    = arr_re;
    if (fill_start) begin
      state_d     = StFill;
      fill_addr_d = '0;
      pattern_d   = (fill_ones == FILL_ONES) ? '1 : '0;
    end else if (state_q == StFill) begin
      fill_addr_d = fill_addr_q + 1'b1;
      if (fill_addr_q == ADDR_W'(DEPTH - 1)) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= StFill;
      fill_addr_q <= '0;
      pattern_q   <= {DATA_W{FILL_ZEROS}};
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      pattern_q   <= pattern_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Write port mux: the sweep owns the array while busy, the user port otherwise.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = addr;
    wr_data   = wdata;
    if (state_q == StFill) begin
      arr_we    = 1'b1;
      arr_waddr = fill_addr_q;
      wr_data   = pattern_q;
    end else if (accept && we) begin
      arr_we    = 1'b1;
    end
  end

`ifdef RAM_BANK_PARITY_EN
  logic wr_par;
  // Injection only applies to user writes; the sweep always stores correct parity.
  assign wr_par    = parity_even(MaxParityW'(wr_data)) ^ (parity_inj & (state_q == StIdle));
  assign arr_wdata = {wr_par, wr_data};
  assign rerr      = rvalid_q & (arr_rdata[DATA_W] ^ parity_even(MaxParityW'(arr_rdata[DATA_W-1:0])));
`else
  assign arr_wdata = wr_data;
`endif

  ram_bank_array #(
    .DataW (StoreW),
    .AddrW (ADDR_W)
  ) u_array (
    .clk     (clk),
    .clear_n (clear_n),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .raddr_i (addr),
    .rdata_o (arr_rdata)
  );

  assign rdata  = arr_rdata[DATA_W-1:0];
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: directed, table-driven bench for ram_bank (DATA_W=4, ADDR_W=2).
module tb_ram_bank;

  localparam int DW = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          clear_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          fill_start = 1'b0;
  logic          fill_ones = 1'b0;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
`ifdef RAM_BANK_PARITY_EN
  logic          parity_inj = 1'b0;
  logic          rerr;
`endif

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_rvalid;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl [15];

  ram_bank #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .fill_start (fill_start),
    .fill_ones  (fill_ones),
`ifdef RAM_BANK_PARITY_EN
    .parity_inj (parity_inj),
    .rerr       (rerr),
`endif
    .ready      (ready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 16) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  // Exactly four busy cycles with ready low, then idle and ready.
  task automatic check_sweep(input string name);
    for (int i = 0; i < 4; i++) begin
      chk({name, "_busy"}, 32'(busy), 32'd1);
      chk({name, "_ready_low"}, 32'(ready), 32'd0);
      tick();
    end
    chk({name, "_done"}, 32'(busy), 32'd0);
    chk({name, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    #1;
    chk("wr_ready", 32'(ready), 32'd1);
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req = 1'b1; we = 1'b0; addr = a;
    tick();
    req = 1'b0;
    chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({name, "_rdata"}, 32'(rdata), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // {req, we, addr, wdata, exp_rvalid, exp_rdata}
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 4'h0, 1'b1, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 2'd2, 4'h0, 1'b1, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 2'd3, 4'h0, 1'b1, 4'h0};
    tbl[4]  = '{1'b1, 1'b1, 2'd1, 4'h3, 1'b0, 4'h0};
    tbl[5]  = '{1'b1, 1'b0, 2'd1, 4'h0, 1'b1, 4'h3};
    tbl[6]  = '{1'b1, 1'b0, 2'd2, 4'h0, 1'b1, 4'h0};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0};
    tbl[8]  = '{1'b1, 1'b1, 2'd3, 4'h7, 1'b0, 4'h0};
    tbl[9]  = '{1'b1, 1'b0, 2'd3, 4'h0, 1'b1, 4'h7};
    tbl[10] = '{1'b1, 1'b1, 2'd0, 4'hA, 1'b0, 4'h7};
    tbl[11] = '{1'b1, 1'b1, 2'd2, 4'h5, 1'b0, 4'h7};
    tbl[12] = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 4'hA};
    tbl[13] = '{1'b1, 1'b0, 2'd2, 4'h0, 1'b1, 4'h5};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h5};

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    clear_n = 1'b1;
    check_sweep("rst_sweep");

    // Table: zero contents, writes, read-after-write, back-to-back reads, hold
    for (int i = 0; i < 15; i++) begin
      req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata;
      tick();
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].exp_rvalid));
      chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tbl[i].exp_rdata));
    end
    req = 1'b0; we = 1'b0;

    // Ones fill with a read held pending through the sweep
    do_write(2'd3, 4'h7);
    fill_start = 1'b1; fill_ones = 1'b1;
    #1;
    chk("fill1_start_ready", 32'(ready), 32'd0);
    tick();
    fill_start = 1'b0; fill_ones = 1'b0;
    req = 1'b1; we = 1'b0; addr = 2'd3;
    for (int i = 0; i < 4; i++) begin
      chk("fill1_busy", 32'(busy), 32'd1);
      chk("fill1_ready_low", 32'(ready), 32'd0);
      tick();
      chk("fill1_no_accept", 32'(rvalid), 32'd0);
    end
    chk("fill1_done", 32'(busy), 32'd0);
    chk("fill1_ready", 32'(ready), 32'd1);
    tick();
    req = 1'b0;
    chk("fill1_held_rvalid", 32'(rvalid), 32'd1);
    chk("fill1_held_rdata", 32'(rdata), 32'hF);
    for (int a = 0; a < 4; a++) do_read($sformatf("fill1_rd%0d", a), AW'(a), 4'hF);

    // fill_start beats a same-cycle write
    do_write(2'd2, 4'h6);
    do_read("prio_pre", 2'd2, 4'h6);
    fill_start = 1'b1; fill_ones = 1'b0;
    req = 1'b1; we = 1'b1; addr = 2'd2; wdata = 4'h9;
    #1;
    chk("prio_ready", 32'(ready), 32'd0);
    tick();
    fill_start = 1'b0; req = 1'b0; we = 1'b0;
    chk("prio_busy", 32'(busy), 32'd1);
    wait_idle("prio_sweep");
    do_read("prio_rd", 2'd2, 4'h0);

    // Read in last idle cycle, then reset two cycles into a ones sweep
    do_write(2'd1, 4'hC);
    req = 1'b1; we = 1'b0; addr = 2'd1;
    tick();
    req = 1'b0;
    fill_start = 1'b1; fill_ones = 1'b1;
    #1;
    chk("last_idle_rvalid", 32'(rvalid), 32'd1);
    chk("last_idle_rdata", 32'(rdata), 32'hC);
    tick();
    fill_start = 1'b0; fill_ones = 1'b0;
    chk("last_idle_pulse_end", 32'(rvalid), 32'd0);
    chk("midfill_busy", 32'(busy), 32'd1);
    tick();
    tick();
    clear_n = 1'b0;
    #1;
    chk("midfill_rst_rdata", 32'(rdata), 32'd0);
    chk("midfill_rst_rvalid", 32'(rvalid), 32'd0);
    chk("midfill_rst_busy", 32'(busy), 32'd1);
    tick();
    clear_n = 1'b1;
    check_sweep("rst2_sweep");
    for (int a = 0; a < 4; a++) do_read($sformatf("rst2_rd%0d", a), AW'(a), 4'h0);

    // Reset drops a pending rvalid
    do_write(2'd0, 4'hF);
    do_read("drop_rd", 2'd0, 4'hF);
    clear_n = 1'b0;
    #1;
    chk("drop_rvalid", 32'(rvalid), 32'd0);
    chk("drop_rdata", 32'(rdata), 32'd0);
    tick();
    clear_n = 1'b1;
    wait_idle("drop_sweep");

`ifdef RAM_BANK_PARITY_EN
    parity_inj = 1'b1;
    do_write(2'd0, 4'h5);
    parity_inj = 1'b0;
    do_read("par_inj_rd", 2'd0, 4'h5);
    chk("par_inj_rerr", 32'(rerr), 32'd1);
    tick();
    chk("par_rerr_clear", 32'(rerr), 32'd0);
    do_write(2'd0, 4'h5);
    do_read("par_ok_rd", 2'd0, 4'h5);
    chk("par_ok_rerr", 32'(rerr), 32'd0);
    do_read("par_fill_rd", 2'd1, 4'h0);
    chk("par_fill_rerr", 32'(rerr), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
